decode_stage: RTL

- Registered RV32I decode pipeline stage between the fetch buffer and execute.
- Accepts one instruction per cycle over a valid/ready handshake.
- Reads source operands through a two-port register-file read interface and selects ALU command, memory access type and operands.
- Holds results in an output register with an optional skid entry, so back-pressure from execute never drops an instruction.
- Adds flush, illegal-instruction flagging and writeback/store metadata that the earlier combinational decoder lacked.

---
 rtl/decode_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage. Decodes one instruction per cycle into an ALU/memory bundle
// held in an output register, with an optional skid entry to absorb execute back-pressure.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter bit          SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ops,
  output logic [3:0]      out_access_type,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage: only XLEN = 32 is supported");
  end

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] AluSeq  = 4'd10;
  localparam logic [3:0] AluSne  = 4'd11;
  localparam logic [3:0] AluSge  = 4'd12;
  localparam logic [3:0] AluSgeu = 4'd13;

  localparam logic [3:0] AccNone = 4'd0;
  localparam logic [3:0] AccLb   = 4'd1;
  localparam logic [3:0] AccLh   = 4'd2;
  localparam logic [3:0] AccLw   = 4'd3;
  localparam logic [3:0] AccLbu  = 4'd4;
  localparam logic [3:0] AccLhu  = 4'd5;
  localparam logic [3:0] AccSb   = 4'd6;
  localparam logic [3:0] AccSh   = 4'd7;
  localparam logic [3:0] AccSw   = 4'd8;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic [3:0]      alu;
    logic [3:0]      access;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } bundle_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_f;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic            legal, wr;
  bundle_t         dec;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_f     = in_instr[11:7];

  assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
  assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
  assign shamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    legal  = 1'b1;
    wr     = 1'b0;
    case (opcode)
      OpLui: begin
        dec.op1 = imm_u;
        dec.imm = imm_u;
        wr      = 1'b1;
      end
      OpAuipc: begin
        dec.op1 = imm_u;
        dec.op2 = in_pc;
        dec.imm = imm_u;
        wr      = 1'b1;
      end
      OpJal: begin
        dec.op1 = imm_j;
        dec.op2 = in_pc;
        dec.imm = imm_j;
        wr      = 1'b1;
      end
      OpJalr: begin
        dec.op1 = rs1_val;
        dec.op2 = imm_i;
        dec.imm = imm_i;
        wr      = 1'b1;
        legal   = (funct3 == 3'b000);
      end
      OpBranch: begin
        dec.op1 = rs1_val;
        dec.op2 = rs2_val;
        dec.imm = imm_b;
        case (funct3)
          3'b000:  dec.alu = AluSeq;
          3'b001:  dec.alu = AluSne;
          3'b100:  dec.alu = AluSlt;
          3'b101:  dec.alu = AluSge;
          3'b110:  dec.alu = AluSltu;
          3'b111:  dec.alu = AluSgeu;
          default: legal   = 1'b0;
        endcase
      end
      OpLoad: begin
        dec.op1 = rs1_val;
        dec.op2 = imm_i;
        dec.imm = imm_i;
        wr      = 1'b1;
        case (funct3)
          3'b000:  dec.access = AccLb;
          3'b001:  dec.access = AccLh;
          3'b010:  dec.access = AccLw;
          3'b100:  dec.access = AccLbu;
          3'b101:  dec.access = AccLhu;
          default: legal      = 1'b0;
        endcase
      end
      OpStore: begin
        dec.op1        = rs1_val;
        dec.op2        = imm_s;
        dec.imm        = imm_s;
        dec.store_data = rs2_val;
        case (funct3)
          3'b000:  dec.access = AccSb;
          3'b001:  dec.access = AccSh;
          3'b010:  dec.access = AccSw;
          default: legal      = 1'b0;
        endcase
      end
      OpImm: begin
        dec.op1 = rs1_val;
        dec.op2 = imm_i;
        dec.imm = imm_i;
        wr      = 1'b1;
        case (funct3)
          3'b000: dec.alu = AluAdd;
          3'b010: dec.alu = AluSlt;
          3'b011: dec.alu = AluSltu;
          3'b100: dec.alu = AluXor;
          3'b110: dec.alu = AluOr;
          3'b111: dec.alu = AluAnd;
          3'b001: begin
            dec.alu = AluSll;
            dec.op2 = shamt;
            legal   = (funct7 == 7'b0000000);
          end
          default: begin
            dec.op2 = shamt;
            dec.alu = (funct7 == 7'b0100000) ? AluSra : AluSrl;
            legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      OpReg: begin
        dec.op1 = rs1_val;
        dec.op2 = rs2_val;
        wr      = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.alu = AluAdd;
            3'b001:  dec.alu = AluSll;
            3'b010:  dec.alu = AluSlt;
            3'b011:  dec.alu = AluSltu;
            3'b100:  dec.alu = AluXor;
            3'b101:  dec.alu = AluSrl;
            3'b110:  dec.alu = AluOr;
            default: dec.alu = AluAnd;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu = AluSub;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu = AluSra;
        end else begin
          legal = 1'b0;
        end
      end
      // FENCE, ECALL and EBREAK travel down as no-op bundles with no writeback.
      OpFence:  legal = (funct3 == 3'b000);
      OpSystem: legal = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
      default:  legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end else begin
      dec.rd    = wr ? rd_f : 5'd0;
      dec.rd_we = wr && (rd_f != 5'd0);
    end
  end

  logic    out_valid_q, out_valid_d;
  bundle_t out_q, out_d;
  logic    in_fire, out_fire;

  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = out_valid_q && out_ready;

  if (SKID) begin : g_skid
    logic    skid_valid_q, skid_valid_d, ready_q;
    bundle_t skid_q, skid_d;

    assign in_ready = ready_q;

    always_comb begin
      out_valid_d  = out_valid_q;
      out_d        = out_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (flush) begin
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
      end else if (out_fire) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          out_d = dec;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        if (out_valid_q) begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end else begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end
      end
    end

    // ready_q mirrors !skid_valid_q once out of reset, so in_fire never coincides with a full skid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_valid_q <= 1'b0;
        skid_q       <= '0;
        ready_q      <= 1'b0;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_q       <= skid_d;
        ready_q      <= !skid_valid_d;
      end
    end
  end else begin : g_no_skid
    logic alive_q;

    assign in_ready = alive_q && (!out_valid_q || out_ready);

    always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (flush) begin
        out_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        alive_q <= 1'b0;
      end else begin
        alive_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_alu_ops     = out_q.alu;
  assign out_access_type = out_q.access;
  assign out_op1         = out_q.op1;
  assign out_op2         = out_q.op2;
  assign out_store_data  = out_q.store_data;
  assign out_imm         = out_q.imm;
  assign out_pc          = out_q.pc;
  assign out_rd          = out_q.rd;
  assign out_rd_we       = out_q.rd_we;
  assign out_illegal     = out_q.illegal;

endmodule
